// File: rtl/pwm_duty_ramp_if.sv
// Target-duty handshake and ramp outputs between a controller and pwm_duty_ramp.
// The ramp block takes the slave side.
interface pwm_duty_ramp_if #(
  parameter int R     = 8,
  parameter int TIMER = 16
);
  logic             en;
  logic [R:0]       target_duty;
  logic             target_valid;
  logic             target_ready;
  logic [R:0]       step_size;
  logic [TIMER-1:0] update_period;
  logic [R:0]       duty;
  logic             busy;
  logic             done;

  modport master (
    output en, target_duty, target_valid, step_size, update_period,
    input  target_ready, duty, busy, done
  );

  modport slave (
    input  en, target_duty, target_valid, step_size, update_period,
    output target_ready, duty, busy, done
  );
endinterface

// File: rtl/pwm_duty_ramp.sv
// Soft-start slew limiter that walks the PWM duty toward an accepted target
// in bounded steps, one step per programmable update interval.
//
//   state | meaning
//   IDLE  | duty held; a target may be accepted while en is high
//   RAMP  | stepping duty toward tgt on each interval tick
module pwm_duty_ramp #(
  parameter int R     = 8,
  parameter int TIMER = 16
) (
  input logic           clk,
  input logic           reset_n,
  pwm_duty_ramp_if.slave bus
);
  typedef enum logic {IDLE, RAMP} state_t;

  localparam logic [R:0] FULL_SCALE = {1'b1, {R{1'b0}}};

  state_t           state_q, state_d;
  logic [R:0]       duty_q, duty_d;
  logic [R:0]       tgt_q, tgt_d;
  logic [R:0]       stp_q, stp_d;
  logic [TIMER-1:0] cnt_q, cnt_d;
  logic [TIMER-1:0] period_q, period_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [R:0]       gap;
  logic [R:0]       stepped;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      duty_q   <= '0;
      tgt_q    <= '0;
      stp_q    <= '0;
      cnt_q    <= '0;
      period_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      tgt_q    <= tgt_d;
      stp_q    <= stp_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    tgt_d    = tgt_q;
    stp_d    = stp_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    // Clamp to tgt when within one step so the output never overshoots.
    gap = (duty_q < tgt_q) ? (tgt_q - duty_q) : (duty_q - tgt_q);
    if (gap <= stp_q) begin
      stepped = tgt_q;
    end else if (duty_q < tgt_q) begin
      stepped = duty_q + stp_q;
    end else begin
      stepped = duty_q - stp_q;
    end

    if (!bus.en) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.target_valid) begin
            tgt_d    = (bus.target_duty > FULL_SCALE) ? FULL_SCALE : bus.target_duty;
            stp_d    = (bus.step_size == '0) ? (R+1)'(1) : bus.step_size;
            cnt_d    = bus.update_period;
            period_d = bus.update_period;
            busy_d   = 1'b1;
            state_d  = RAMP;
          end
        end
        RAMP: begin
          if (duty_q == tgt_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TIMER'(1);
          end else begin
            cnt_d  = period_q;
            duty_d = stepped;
            if (stepped == tgt_q) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.target_ready = reset_n && bus.en && (state_q == IDLE);
  assign bus.duty         = duty_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Scoreboard bench for pwm_duty_ramp: expected duty/done events and their
// edge offsets from the accepting edge are queued, then matched as they appear.
module tb_pwm_duty_ramp;
  localparam int R     = 8;
  localparam int TIMER = 16;

  typedef struct {
    string tag;
    int    duty;
    bit    done;
    int    ofs;
  } evt_t;

  logic clk = 1'b0;
  logic reset_n;
  int   edge_cnt = 0;
  int   accept_edge = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  logic [R:0] prev_duty = '0;
  evt_t sb[$];

  pwm_duty_ramp_if #(.R(R), .TIMER(TIMER)) bus ();

  pwm_duty_ramp #(.R(R), .TIMER(TIMER)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic exp_evt(input string tag, input int d, input bit dn, input int ofs);
    evt_t e;
    e.tag = tag; e.duty = d; e.done = dn; e.ofs = ofs;
    sb.push_back(e);
  endtask

  task automatic send(input int tgt, input int stp, input int per);
    @(negedge clk);
    bus.target_duty   = (R+1)'(tgt);
    bus.step_size     = (R+1)'(stp);
    bus.update_period = TIMER'(per);
    bus.target_valid  = 1'b1;
    accept_edge       = edge_cnt + 1;
    #1 check_eq("ready_idle", 32'(bus.target_ready), 1);
    @(negedge clk);
    bus.target_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq("drain", sb.size(), 0);
    if (sb.size() != 0) sb.delete();
  endtask

  // Any duty change or done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mon_en && reset_n === 1'b1) begin
      if (bus.duty !== prev_duty || bus.done !== 1'b0) begin
        if (sb.size() == 0) begin
          check_eq("spurious_duty", 32'(bus.duty), 32'(prev_duty));
          check_eq("spurious_done", 32'(bus.done), 0);
        end else begin
          evt_t e;
          e = sb.pop_front();
          check_eq({e.tag, "_duty"}, 32'(bus.duty), e.duty);
          check_eq({e.tag, "_done"}, 32'(bus.done), 32'(e.done));
          check_eq({e.tag, "_edge"}, edge_cnt - accept_edge, e.ofs);
        end
      end
    end
    prev_duty = bus.duty;
  end

  initial begin
    reset_n           = 1'b1;
    bus.en            = 1'b1;
    bus.target_valid  = 1'b0;
    bus.target_duty   = '0;
    bus.step_size     = '0;
    bus.update_period = '0;

    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_duty", 32'(bus.duty), 0);
    check_eq("rst_busy", 32'(bus.busy), 0);
    check_eq("rst_done", 32'(bus.done), 0);
    check_eq("rst_ready", 32'(bus.target_ready), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1 check_eq("post_rst_ready", 32'(bus.target_ready), 1);
    mon_en = 1'b1;

    // up ramp 0 -> 64, step 16, period 3
    for (int k = 1; k <= 4; k++) exp_evt("up", 16 * k, k == 4, 4 * k);
    send(64, 16, 3);
    #1 check_eq("up_busy", 32'(bus.busy), 1);
    wait_drain(40);

    // down 64 -> 10, step 20, period 0
    exp_evt("dn", 44, 0, 1);
    exp_evt("dn", 24, 0, 2);
    exp_evt("dn", 10, 1, 3);
    send(10, 20, 0);
    wait_drain(20);

    // clamp: set 250, then 300 with zero step -> 1/cycle up to 256
    exp_evt("pre250", 250, 1, 1);
    send(250, 255, 0);
    wait_drain(10);
    for (int k = 1; k <= 6; k++) exp_evt("clamp", 250 + k, k == 6, k);
    send(300, 0, 0);
    wait_drain(20);

    // equal target at 128
    exp_evt("pre128", 128, 1, 1);
    send(128, 200, 0);
    wait_drain(10);
    exp_evt("eq", 128, 1, 1);
    send(128, 5, 7);
    #1 check_eq("eq_busy1", 32'(bus.busy), 1);
    @(negedge clk);
    #1 check_eq("eq_busy0", 32'(bus.busy), 0);
    wait_drain(10);

    // abort: 0 -> 200 step 10 period 1, en drop at 80
    exp_evt("pre0", 0, 1, 1);
    send(0, 255, 0);
    wait_drain(10);
    for (int k = 1; k <= 8; k++) exp_evt("ab", 10 * k, 1'b0, 2 * k);
    send(200, 10, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.target_duty  = 9'd5;
      bus.target_valid = 1'b1;
      #1 check_eq("ramp_ready", 32'(bus.target_ready), 0);
    end
    bus.target_valid = 1'b0;
    wait_drain(40);
    bus.en = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      check_eq("abort_busy", 32'(bus.busy), 0);
      check_eq("abort_ready", 32'(bus.target_ready), 0);
    end
    bus.en = 1'b1;
    @(negedge clk);
    #1 check_eq("reen_ready", 32'(bus.target_ready), 1);
    repeat (6) @(negedge clk);
    #1;
    check_eq("reen_duty", 32'(bus.duty), 80);
    check_eq("reen_busy", 32'(bus.busy), 0);

    // async reset mid-ramp
    exp_evt("rr", 90, 0, 2);
    send(200, 10, 1);
    wait_drain(10);
    mon_en = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check_eq("mid_rst_duty", 32'(bus.duty), 0);
    check_eq("mid_rst_busy", 32'(bus.busy), 0);
    check_eq("mid_rst_ready", 32'(bus.target_ready), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
